// File: rtl/rct_motion_pkg.sv
// Shared types and constants for the frame-synchronous rectangle motion controller.
// Positions are integer pixels; vertical position and velocity carry FRAC_BITS of fraction.
package rct_motion_pkg;

  localparam int POS_W     = 12;
  localparam int VEL_W     = 12;
  localparam int FRAC_BITS = 4;
  localparam int YFP_W     = POS_W + FRAC_BITS;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DRAG = 2'd1;
  localparam state_t ST_FALL = 2'd2;
  localparam state_t ST_STOP = 2'd3;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                 input logic [POS_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/rct_edge_tick.sv
// Rising-edge detector producing a one-clock tick per frame strobe.
// Reusable by any controller that must update exactly once per frame.
module rct_edge_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic tick
);

  logic level_q;
  logic level_d;

  assign level_d = level;
  assign tick    = level & ~level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/rct_motion_ctl.sv
// Drag / gravity-fall / damped-bounce sequencer for the drawn rectangle position.
// All state advances only on the vsync rising-edge tick so the drawn image never tears.
module rct_motion_ctl
  import rct_motion_pkg::*;
#(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int RCT_W      = 48,
  parameter int RCT_H      = 64,
  parameter int GRAVITY    = 8,
  parameter int VMAX       = 320,
  parameter int DAMP_SHIFT = 1,
  parameter int V_STOP     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic [POS_W-1:0] mouse_xpos,
  input  logic [POS_W-1:0] mouse_ypos,
  input  logic             mouse_left,
  input  logic             mouse_right,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             moving
);

  localparam logic [POS_W-1:0] XMAX     = POS_W'(H_ACTIVE - RCT_W);
  localparam logic [POS_W-1:0] FLOOR    = POS_W'(V_ACTIVE - RCT_H);
  localparam logic [YFP_W-1:0] FLOOR_FP = {FLOOR, {FRAC_BITS{1'b0}}};

  logic tick;

  state_t                   state_q, state_d;
  logic [POS_W-1:0]         x_q, x_d;
  logic [YFP_W-1:0]         yfp_q, yfp_d;
  logic signed [VEL_W-1:0]  vel_q, vel_d;
  logic                     moving_q, moving_d;

  logic signed [VEL_W:0]    vel_sum;
  logic signed [VEL_W-1:0]  vel_new;
  logic signed [YFP_W+1:0]  y_sum;
  logic [YFP_W-1:0]         y_next;
  logic signed [VEL_W-1:0]  vel_damped;

  rct_edge_tick u_tick (
    .clk   (clk),
    .rst_n (rst),
    .level (vsync),
    .tick  (tick)
  );

  // Gravity step: saturate speed, then move with underflow clamped to the top of screen.
  always_comb begin
    vel_sum    = (VEL_W+1)'(vel_q) + (VEL_W+1)'(GRAVITY);
    vel_new    = (vel_sum > (VEL_W+1)'(VMAX)) ? VEL_W'(VMAX) : vel_sum[VEL_W-1:0];
    y_sum      = $signed({2'b00, yfp_q}) + (YFP_W+2)'(vel_new);
    if (y_sum[YFP_W+1]) begin
      y_next = '0;
    end else if (y_sum[YFP_W]) begin
      y_next = '1;
    end else begin
      y_next = y_sum[YFP_W-1:0];
    end
    vel_damped = vel_new >>> DAMP_SHIFT;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    yfp_d   = yfp_q;
    vel_d   = vel_q;
    if (tick) begin
      if (mouse_right) begin
        state_d = ST_IDLE;
        x_d     = '0;
        yfp_d   = '0;
        vel_d   = '0;
      end else if (mouse_left || state_q == ST_DRAG) begin
        // Releasing the button still takes this tick's mouse sample as the drop point.
        state_d = mouse_left ? ST_DRAG : ST_FALL;
        x_d     = clamp_pos(mouse_xpos, XMAX);
        yfp_d   = {clamp_pos(mouse_ypos, FLOOR), {FRAC_BITS{1'b0}}};
        vel_d   = '0;
      end else begin
        case (state_q)
          ST_FALL: begin
            yfp_d = y_next;
            vel_d = vel_new;
            if (y_next[YFP_W-1:FRAC_BITS] >= FLOOR) begin
              yfp_d = FLOOR_FP;
              if (vel_damped < VEL_W'(V_STOP)) begin
                state_d = ST_STOP;
                vel_d   = '0;
              end else begin
                vel_d   = -vel_damped;
              end
            end
          end
          ST_STOP: begin
            yfp_d = FLOOR_FP;
            vel_d = '0;
          end
          default: begin
          end
        endcase
      end
    end
    moving_d = (state_d == ST_FALL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      yfp_q    <= '0;
      vel_q    <= '0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      yfp_q    <= yfp_d;
      vel_q    <= vel_d;
      moving_q <= moving_d;
    end
  end

  assign xpos   = x_q;
  assign ypos   = yfp_q[YFP_W-1:FRAC_BITS];
  assign moving = moving_q;

endmodule

// File: tb/tb_rct_motion_ctl.sv
// Scoreboard bench for rct_motion_ctl: a physics-level reference model predicts the
// rectangle after every frame tick, and a monitor compares the registered outputs.
module tb_rct_motion_ctl;

  localparam int XMAX  = 800 - 48;
  localparam int FLOOR = 600 - 64;

  typedef struct {
    int x;
    int y;
    bit mv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic        mouse_right;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        moving;

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];

  // Reference model: mode 0 idle, 1 dragging, 2 falling, 3 resting; y and velocity in 1/16 px
  int m_mode;
  int m_x;
  int m_y16;
  int m_vel;

  logic vs_prev;
  logic pending;

  rct_motion_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .mouse_xpos  (mouse_xpos),
    .mouse_ypos  (mouse_ypos),
    .mouse_left  (mouse_left),
    .mouse_right (mouse_right),
    .xpos        (xpos),
    .ypos        (ypos),
    .moving      (moving)
  );

  always #5 clk = ~clk;

  // Bench-side frame detector tells the monitor which cycle should carry a fresh result.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_prev <= 1'b0;
      pending <= 1'b0;
    end else begin
      pending <= vsync & ~vs_prev;
      vs_prev <= vsync;
    end
  end

  function automatic exp_t modelOut();
    exp_t e;
    e.x  = m_x;
    e.y  = m_y16 / 16;
    e.mv = (m_mode == 2);
    return e;
  endfunction

  task automatic modelReset();
    m_mode = 0;
    m_x    = 0;
    m_y16  = 0;
    m_vel  = 0;
  endtask

  // One frame of physics: right click wins, then grabbing, then free motion.
  task automatic modelStep(input bit l, input bit r, input int mx, input int my);
    if (r) begin
      modelReset();
    end else if (l || m_mode == 1) begin
      m_mode = l ? 1 : 2;
      m_x    = (mx > XMAX) ? XMAX : mx;
      m_y16  = ((my > FLOOR) ? FLOOR : my) * 16;
      m_vel  = 0;
    end else if (m_mode == 2) begin
      m_vel = m_vel + 8;
      if (m_vel > 320) m_vel = 320;
      m_y16 = m_y16 + m_vel;
      if (m_y16 < 0) m_y16 = 0;
      if (m_y16 / 16 >= FLOOR) begin
        m_y16 = FLOOR * 16;
        if (m_vel / 2 < 16) begin
          m_mode = 3;
          m_vel  = 0;
        end else begin
          m_vel = -(m_vel / 2);
        end
      end
    end else if (m_mode == 3) begin
      m_y16 = FLOOR * 16;
      m_vel = 0;
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    checks++;
    if (int'(xpos) != e.x || int'(ypos) != e.y || moving !== e.mv) begin
      errors++;
      $display("[TB] FAIL %s: got x=%0d y=%0d moving=%0b, want x=%0d y=%0d moving=%0b",
               name, xpos, ypos, moving, e.x, e.y, e.mv);
    end
  endtask

  task automatic scramble();
    mouse_xpos  = 12'($urandom_range(0, 4095));
    mouse_ypos  = 12'($urandom_range(0, 4095));
    mouse_left  = 1'($urandom_range(0, 1));
    mouse_right = 1'($urandom_range(0, 1));
  endtask

  // One frame: present inputs on the rising vsync, then scramble them to prove they are ignored.
  task automatic applyStimulus(input bit l, input bit r, input int mx, input int my,
                               input int hi_clks, input int lo_clks);
    exp_t e;
    @(negedge clk);
    mouse_xpos  = 12'(mx);
    mouse_ypos  = 12'(my);
    mouse_left  = l;
    mouse_right = r;
    vsync       = 1'b1;
    modelStep(l, r, mx, my);
    e = modelOut();
    sb_q.push_back(e);
    for (int i = 1; i < hi_clks; i++) begin
      @(negedge clk);
      scramble();
      checkOutput("hold_high", e);
    end
    for (int i = 0; i < lo_clks; i++) begin
      @(negedge clk);
      vsync = 1'b0;
      scramble();
      checkOutput("hold_low", e);
    end
  endtask

  // Monitor: pops one prediction for every frame result the DUT presents.
  always @(negedge clk) begin
    if (pending) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: output at t=%0t with no prediction queued", $time);
      end else begin
        checkOutput("frame", sb_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t zero;
    zero.x  = 0;
    zero.y  = 0;
    zero.mv = 1'b0;

    rst         = 1'b0;
    vsync       = 1'b0;
    mouse_xpos  = '0;
    mouse_ypos  = '0;
    mouse_left  = 1'b0;
    mouse_right = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_state", zero);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] grab with out-of-range mouse");
    applyStimulus(1, 0, 900, 700, 2, 2);
    applyStimulus(1, 0, 100, 0, 2, 2);

    $display("[TB] release at top, fall and bounce to rest");
    for (int i = 0; i < 120; i++) applyStimulus(0, 0, $urandom_range(0, 1023), 0, 2, 2);

    $display("[TB] right and left on same tick while falling");
    applyStimulus(1, 0, 300, 100, 2, 2);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 2, 2);
    applyStimulus(1, 1, 500, 500, 2, 2);

    $display("[TB] asynchronous reset while falling");
    applyStimulus(1, 0, 50, 200, 2, 2);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 2, 2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("async_reset", zero);
    modelReset();
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] vsync stuck high then low during a fall");
    applyStimulus(1, 0, 10, 0, 2, 2);
    applyStimulus(0, 0, 0, 0, 2, 2);
    applyStimulus(0, 0, 0, 0, 60, 60);
    for (int i = 0; i < 45; i++) applyStimulus(0, 0, 0, 0, 2, 2);

    $display("[TB] randomized frames");
    for (int i = 0; i < 250; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                    $urandom_range(0, 1023), $urandom_range(0, 1023), 2, 2);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d predictions left, want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
